rll_id_field_parser: RTL and testbench
======================================

Name: rll_id_field_parser

Overview:
- Downstream consumer of the RLL(2,7) decoder and the RLL address-mark detector in the ST-506 read path.
- Arms on an ID address mark, collects the following ID field bytes (cylinder, head, sector), and checks CRC-16/CCITT over the field.
- Presents the captured sector header to the track/sector sequencer.
- Aborts on a missing byte (timeout), and restarts cleanly on a new mark.

Parameters:
- CRC_INIT, 16'hFFFF, CRC register preset loaded when a mark is accepted.
- TIMEOUT, 512, max clk cycles allowed between accepted bytes while collecting (range 2..65535).
- HEAD_MASK, 8'h0F, AND-mask applied to the head byte before output.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- enable  in  1  block enable; when low, state holds and all pulse outputs are forced 0
- id_mark  in  1  1-cycle pulse: ID address mark seen
- byte_in  in  8  decoded byte
- byte_valid  in  1  1-cycle strobe qualifying byte_in
- busy  out  1  high while collecting an ID field
- id_valid  out  1  1-cycle pulse: field complete and CRC good
- crc_error  out  1  1-cycle pulse: field complete, CRC bad
- timeout_error  out  1  1-cycle pulse: byte gap exceeded TIMEOUT
- cylinder  out  16  {cyl_hi, cyl_lo} of last completed field
- head  out  8  head byte & HEAD_MASK of last completed field
- sector  out  8  sector number of last completed field
- crc_calc  out  16  CRC register value after the 4 header bytes (debug)

Behaviour:
- Reset (reset_n=0 at a clk edge) clears everything: state=IDLE, busy=0, all pulses 0, cylinder=0, head=0, sector=0, crc_calc=0, byte index=0, timer=0, CRC register=CRC_INIT.
- Reset asserted mid-field discards the partial field; no pulse is emitted.
- Gating: all logic advances only when enable=1. With enable=0 the pulses are 0 and the timer is frozen.
- Field format after the mark is exactly 6 bytes, in order: cyl_hi, cyl_lo, head, sector, crc_hi, crc_lo.
- CRC: polynomial x^16+x^12+x^5+1, MSB-first, no reflection, no final XOR. One byte is folded per cycle, combinationally within the accepting cycle.
- CRC pass criterion: the CRC register after all 6 bytes equals 16'h0000 (residue check).
- crc_calc latches the register value after byte index 3.
- States:
  - IDLE: busy=0. id_mark -> COLLECT, with index=0, timer=0, CRC register=CRC_INIT.
  - COLLECT: busy=1.
    - Each byte_valid: store the byte into the index slot, fold it into the CRC, index+1, timer=0.
    - Timer increments on every enabled cycle without byte_valid.
    - timer reaching TIMEOUT-1 with no byte -> timeout_error pulse next cycle, go to IDLE, outputs unchanged.
    - Accepting the 6th byte (index 5) -> CHECK.
  - CHECK: exactly one cycle.
    - Residue==0: update cylinder/head/sector, id_valid=1.
    - Otherwise: crc_error=1, cylinder/head/sector unchanged.
    - Then IDLE, or COLLECT if id_mark is high in this cycle.
- Latency: id_valid/crc_error assert exactly 1 cycle after the byte_valid of crc_lo. busy falls in the same cycle as the pulse.
- Simultaneous id_mark and byte_valid in any state: the mark wins, the byte is discarded, collection restarts at index 0.
- id_mark in COLLECT: restart (re-arm) with no error pulse.
- byte_valid in IDLE: ignored.
- At most one of id_valid/crc_error/timeout_error is high in any cycle.
- Output fields are stable except for the single update cycle.

Test Plan:
- CRC_INIT=16'h0000; id_mark, then bytes 00 00 00 00 00 00 -> id_valid=1 one cycle after the 6th strobe; cylinder=0, head=0, sector=0, crc_calc=0.
- Default params; id_mark, then 01 2C 13 07 followed by the golden-model CRC bytes (gaps of 7 cycles) -> id_valid; cylinder=16'h012C, head=8'h03, sector=8'h07.
- Same stream with bit 0 of the sector byte flipped -> crc_error pulse; cylinder/head/sector keep their prior values; busy=0.
- TIMEOUT=16; id_mark, 2 bytes, then silence -> timeout_error exactly 16 cycles after the last strobe; busy=0; no id_valid.
- id_mark, 3 bytes, then id_mark coincident with byte_valid, then a full valid field -> single id_valid carrying the second field's values; the coincident byte is dropped.
- reset_n=0 for 1 cycle after the 4th byte, then crc bytes sent -> no pulses, all outputs 0. enable=0 for 50 cycles mid-field with TIMEOUT=16 -> no timeout, and the field completes normally afterwards.

Source files
------------

// File: rtl/rll_id_field_parser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rll_id_field_parser : collects and CRC-checks an RLL ID field after a mark.
// Revision 1.0
// ---------------------------------------------------------------------------
module rll_id_field_parser #(
   parameter logic [15:0] CRC_INIT  = 16'hFFFF,
   parameter int unsigned TIMEOUT   = 512,
   parameter logic [7:0]  HEAD_MASK = 8'h0F
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        id_mark,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        busy,
   output logic        id_valid,
   output logic        crc_error,
   output logic        timeout_error,
   output logic [15:0] cylinder,
   output logic [7:0]  head,
   output logic [7:0]  sector,
   output logic [15:0] crc_calc
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      CHECK   = 2'd2
   } state_t;

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [2:0]  idx;
   logic [15:0] timer;
   logic [15:0] crc, crc_nxt;
   logic [7:0]  hdr [4];
   logic        accept, last_byte, time_up;
   logic        pulse_ok, pulse_bad, pulse_to;

   // MSB-first CRC-16/CCITT, one whole byte per call
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else              r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_byte = 1'b0;
      time_up   = 1'b0;
      crc_nxt   = crc_byte(crc, byte_in);
      case (state)
         IDLE: begin
            if (id_mark) state_nxt = COLLECT;
         end
         COLLECT: begin
            // a mark always wins over a coincident byte
            if (id_mark) begin
               state_nxt = COLLECT;
            end else if (byte_valid) begin
               accept = 1'b1;
               if (idx == 3'd5) begin
                  last_byte = 1'b1;
                  state_nxt = CHECK;
               end
            end else if (timer == TIMER_LAST) begin
               time_up   = 1'b1;
               state_nxt = IDLE;
            end
         end
         CHECK: begin
            state_nxt = id_mark ? COLLECT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         idx       <= 3'd0;
         timer     <= 16'd0;
         crc       <= CRC_INIT;
         crc_calc  <= 16'd0;
         cylinder  <= 16'd0;
         head      <= 8'd0;
         sector    <= 8'd0;
         pulse_ok  <= 1'b0;
         pulse_bad <= 1'b0;
         pulse_to  <= 1'b0;
         for (int i = 0; i < 4; i++) hdr[i] <= 8'd0;
      end else if (enable) begin
         state     <= state_nxt;
         pulse_ok  <= 1'b0;
         pulse_bad <= 1'b0;
         pulse_to  <= 1'b0;
         if (id_mark) begin
            idx   <= 3'd0;
            timer <= 16'd0;
            crc   <= CRC_INIT;
         end else if (accept) begin
            idx   <= idx + 3'd1;
            timer <= 16'd0;
            crc   <= crc_nxt;
            if (idx < 3'd4) hdr[idx[1:0]] <= byte_in;
            if (idx == 3'd3) crc_calc <= crc_nxt;
            // residue check: register folds to zero over header plus CRC
            if (last_byte) begin
               if (crc_nxt == 16'h0000) begin
                  pulse_ok <= 1'b1;
                  cylinder <= {hdr[0], hdr[1]};
                  head     <= hdr[2] & HEAD_MASK;
                  sector   <= hdr[3];
               end else begin
                  pulse_bad <= 1'b1;
               end
            end
         end else if (time_up) begin
            pulse_to <= 1'b1;
            timer    <= 16'd0;
         end else if (state == COLLECT) begin
            timer <= timer + 16'd1;
         end
      end
   end

   assign busy          = (state == COLLECT);
   assign id_valid      = pulse_ok  & enable;
   assign crc_error     = pulse_bad & enable;
   assign timeout_error = pulse_to  & enable;

endmodule
`default_nettype wire

// File: tb/tb_rll_id_field_parser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rll_id_field_parser : random + directed bench with a byte-stream model.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_rll_id_field_parser;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b1;
   logic       id_mark = 1'b0;
   logic [7:0] byte_in = 8'd0;
   logic       byte_valid = 1'b0;

   logic        a_busy, a_id_valid, a_crc_error, a_timeout;
   logic [15:0] a_cylinder, a_crc_calc;
   logic [7:0]  a_head, a_sector;
   logic        b_busy, b_id_valid, b_crc_error, b_timeout;
   logic [15:0] b_cylinder, b_crc_calc;
   logic [7:0]  b_head, b_sector;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rll_id_field_parser #(.TIMEOUT(16)) u_a (
      .clk(clk), .reset_n(reset_n), .enable(enable), .id_mark(id_mark),
      .byte_in(byte_in), .byte_valid(byte_valid), .busy(a_busy),
      .id_valid(a_id_valid), .crc_error(a_crc_error), .timeout_error(a_timeout),
      .cylinder(a_cylinder), .head(a_head), .sector(a_sector), .crc_calc(a_crc_calc)
   );

   rll_id_field_parser #(.CRC_INIT(16'h0000)) u_b (
      .clk(clk), .reset_n(reset_n), .enable(enable), .id_mark(id_mark),
      .byte_in(byte_in), .byte_valid(byte_valid), .busy(b_busy),
      .id_valid(b_id_valid), .crc_error(b_crc_error), .timeout_error(b_timeout),
      .cylinder(b_cylinder), .head(b_head), .sector(b_sector), .crc_calc(b_crc_calc)
   );

   // reference model state, index 0 = u_a, 1 = u_b
   bit          m_armed [2];
   int          m_cnt   [2];
   int          m_gap   [2];
   logic [47:0] m_stream[2];
   bit          m_ok [2], m_bad [2], m_to [2];
   logic [15:0] m_cyl [2], m_calc [2];
   logic [7:0]  m_head[2], m_sec [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // CRC over the first nbits of a byte stream, MSB first
   function automatic logic [15:0] ref_crc(input logic [15:0] init, input logic [47:0] s,
                                           input int nbits);
      logic [16:0] r;
      r = {1'b0, init};
      for (int i = 0; i < nbits; i++) begin
         r = {r[15:0], 1'b0};
         if (r[16] ^ s[47-i]) r = r ^ 17'h01021;
      end
      return r[15:0];
   endfunction

   function automatic logic [47:0] make_field(input logic [15:0] init, input logic [31:0] h);
      return {h, ref_crc(init, {h, 16'h0000}, 32)};
   endfunction

   task automatic model_step(input int k);
      logic [15:0] init;
      int          tmo;
      init = (k == 0) ? 16'hFFFF : 16'h0000;
      tmo  = (k == 0) ? 16 : 512;
      if (!reset_n) begin
         m_armed[k] = 0; m_cnt[k] = 0; m_gap[k] = 0; m_stream[k] = '0;
         m_ok[k] = 0; m_bad[k] = 0; m_to[k] = 0;
         m_cyl[k] = '0; m_calc[k] = '0; m_head[k] = '0; m_sec[k] = '0;
      end else if (enable) begin
         m_ok[k] = 0; m_bad[k] = 0; m_to[k] = 0;
         if (id_mark) begin
            m_armed[k] = 1; m_cnt[k] = 0; m_gap[k] = 0;
         end else if (m_armed[k] && byte_valid) begin
            m_stream[k][47-8*m_cnt[k] -: 8] = byte_in;
            m_cnt[k]++;
            m_gap[k] = 0;
            if (m_cnt[k] == 4) m_calc[k] = ref_crc(init, m_stream[k], 32);
            if (m_cnt[k] == 6) begin
               m_armed[k] = 0;
               if (ref_crc(init, m_stream[k], 48) == 16'h0000) begin
                  m_ok[k]   = 1;
                  m_cyl[k]  = m_stream[k][47:32];
                  m_head[k] = m_stream[k][31:24] & 8'h0F;
                  m_sec[k]  = m_stream[k][23:16];
               end else begin
                  m_bad[k] = 1;
               end
            end
         end else if (m_armed[k]) begin
            m_gap[k]++;
            if (m_gap[k] == tmo) begin
               m_armed[k] = 0;
               m_to[k]    = 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("a_busy",      32'(a_busy),      32'(m_armed[0]));
      check("a_id_valid",  32'(a_id_valid),  32'(m_ok[0]  & enable));
      check("a_crc_error", 32'(a_crc_error), 32'(m_bad[0] & enable));
      check("a_timeout",   32'(a_timeout),   32'(m_to[0]  & enable));
      check("a_cylinder",  32'(a_cylinder),  32'(m_cyl[0]));
      check("a_head",      32'(a_head),      32'(m_head[0]));
      check("a_sector",    32'(a_sector),    32'(m_sec[0]));
      check("a_crc_calc",  32'(a_crc_calc),  32'(m_calc[0]));
      check("b_busy",      32'(b_busy),      32'(m_armed[1]));
      check("b_id_valid",  32'(b_id_valid),  32'(m_ok[1]  & enable));
      check("b_crc_error", 32'(b_crc_error), 32'(m_bad[1] & enable));
      check("b_timeout",   32'(b_timeout),   32'(m_to[1]  & enable));
      check("b_cylinder",  32'(b_cylinder),  32'(m_cyl[1]));
      check("b_head",      32'(b_head),      32'(m_head[1]));
      check("b_sector",    32'(b_sector),    32'(m_sec[1]));
      check("b_crc_calc",  32'(b_crc_calc),  32'(m_calc[1]));
   endtask

   task automatic step(input logic mk, input logic bv, input logic [7:0] b,
                       input logic e = 1'b1, input logic r = 1'b1);
      @(negedge clk);
      id_mark = mk; byte_valid = bv; byte_in = b; enable = e; reset_n = r;
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1 compare_all();
   endtask

   task automatic send_bytes(input logic [47:0] s, input int first, input int last, input int gap);
      for (int i = first; i <= last; i++) begin
         repeat (gap) step(1'b0, 1'b0, 8'h00);
         step(1'b0, 1'b1, s[47-8*i -: 8]);
      end
   endtask

   task automatic send_field(input logic [47:0] s, input int gap);
      step(1'b1, 1'b0, 8'h00);
      send_bytes(s, 0, 5, gap);
   endtask

   initial begin
      logic [47:0] f, f2;

      // reset
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_calc", 32'(a_crc_calc), 32'd0);

      // all-zero field with zero preset
      send_field(48'h0, 2);
      check("zero_valid", 32'(b_id_valid), 32'd1);
      check("zero_cyl",   32'(b_cylinder), 32'd0);
      check("zero_calc",  32'(b_crc_calc), 32'd0);

      // golden field
      f = make_field(16'hFFFF, 32'h012C_1307);
      send_field(f, 7);
      check("gold_valid", 32'(a_id_valid), 32'd1);
      check("gold_busy",  32'(a_busy),     32'd0);
      check("gold_cyl",   32'(a_cylinder), 32'h012C);
      check("gold_head",  32'(a_head),     32'h03);
      check("gold_sec",   32'(a_sector),   32'h07);
      step(1'b0, 1'b0, 8'h00);
      check("gold_pulse_len", 32'(a_id_valid), 32'd0);

      // corrupted sector bit
      send_field(f ^ (48'h1 << 16), 7);
      check("bad_crcerr", 32'(a_crc_error), 32'd1);
      check("bad_valid",  32'(a_id_valid),  32'd0);
      check("bad_cyl",    32'(a_cylinder),  32'h012C);
      check("bad_busy",   32'(a_busy),      32'd0);

      // timeout on u_a after two bytes
      step(1'b1, 1'b0, 8'h00);
      send_bytes(f, 0, 1, 0);
      for (int n = 1; n <= 16; n++) begin
         step(1'b0, 1'b0, 8'h00);
         check("tmo_pulse", 32'(a_timeout), (n == 16) ? 32'd1 : 32'd0);
      end
      check("tmo_busy", 32'(a_busy), 32'd0);

      // coincident mark drops the byte, then a second full field
      f2 = make_field(16'hFFFF, 32'hABCD_1E05);
      step(1'b1, 1'b0, 8'h00);
      send_bytes(f, 0, 2, 1);
      step(1'b1, 1'b1, 8'h44);
      send_bytes(f2, 0, 5, 0);
      check("rearm_valid", 32'(a_id_valid), 32'd1);
      check("rearm_cyl",   32'(a_cylinder), 32'hABCD);
      check("rearm_head",  32'(a_head),     32'h0E);
      check("rearm_sec",   32'(a_sector),   32'h05);

      // reset mid-field
      step(1'b1, 1'b0, 8'h00);
      send_bytes(f, 0, 3, 0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      send_bytes(f, 4, 5, 0);
      check("mrst_valid", 32'(a_id_valid), 32'd0);
      check("mrst_cyl",   32'(a_cylinder), 32'd0);
      check("mrst_calc",  32'(a_crc_calc), 32'd0);

      // enable low for 50 cycles mid-field
      step(1'b1, 1'b0, 8'h00);
      send_bytes(f, 0, 2, 0);
      repeat (50) step(1'b0, 1'b0, 8'h00, 1'b0);
      check("en_no_tmo", 32'(a_timeout), 32'd0);
      send_bytes(f, 3, 5, 0);
      check("en_valid", 32'(a_id_valid), 32'd1);
      check("en_cyl",   32'(a_cylinder), 32'h012C);

      // randomized traffic
      for (int it = 0; it < 400; it++) begin
         int sel;
         sel = int'($urandom_range(0, 99));
         if (sel < 12) begin
            f = make_field(($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000, $urandom);
            send_field(f, int'($urandom_range(0, 18)));
         end else if (sel < 16) begin
            repeat (20) step(1'b0, 1'b0, 8'h00);
         end else begin
            step(($urandom_range(0, 99) < 4),
                 ($urandom_range(0, 99) < 45),
                 8'($urandom),
                 ($urandom_range(0, 99) < 90),
                 ($urandom_range(0, 199) != 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
